// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter and its helpers.
package mem_port_arbiter_pkg;

  // Selection policy: fixed priority with starvation promotion, or rotating
  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_t;

  // IDLE arbitrates, ACCESS holds one downstream transaction
  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the arbiter.
interface mem_port_arbiter_if #(
  parameter int NUM_PORTS = 3,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
);
  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]             req_ren;
  logic [NUM_PORTS-1:0]             req_wen;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_PORTS-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_PORTS-1:0][BE_W-1:0]   req_byte_en;
  logic [NUM_PORTS-1:0]             req_lock;
  logic [NUM_PORTS-1:0]             req_busy;
  logic [DATA_W-1:0]                req_rdata;

  logic                             mem_ren;
  logic                             mem_wen;
  logic [ADDR_W-1:0]                mem_addr;
  logic [DATA_W-1:0]                mem_wdata;
  logic [BE_W-1:0]                  mem_byte_en;
  logic                             mem_busy;
  logic [DATA_W-1:0]                mem_rdata;

  logic                             grant_valid;
  logic [ID_W-1:0]                  grant_id;

  // The arbiter itself
  modport slave (
    input  req_ren, req_wen, req_addr, req_wdata, req_byte_en, req_lock,
    output req_busy, req_rdata,
    output mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en,
    input  mem_busy, mem_rdata,
    output grant_valid, grant_id
  );

  // Whoever drives the requests and models the memory
  modport master (
    output req_ren, req_wen, req_addr, req_wdata, req_byte_en, req_lock,
    input  req_busy, req_rdata,
    input  mem_ren, mem_wen, mem_addr, mem_wdata, mem_byte_en,
    output mem_busy, mem_rdata,
    input  grant_valid, grant_id
  );

endinterface

// File: rtl/mem_port_arbiter_picker.sv
// Rotating find-first-set: first set bit at or after 'start', wrapping.
module rr_priority_picker #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic          valid,
  output logic [IW-1:0] index
);

  // Walk N positions from start, keep the first requester found
  always_comb begin
    int pos;
    valid = 1'b0;
    index = '0;
    pos   = 0;
    for (int off = 0; off < N; off++) begin
      pos = int'(start) + off;
      if (pos >= N) pos = pos - N;
      if (!valid && req[IW'(pos)]) begin
        valid = 1'b1;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Merges NUM_PORTS cache-side requesters onto one memory port, with
// fixed/round-robin selection, starvation promotion and an LR/SC lock.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int        NUM_PORTS    = 3,
  parameter int        ADDR_W       = 32,
  parameter int        DATA_W       = 32,
  parameter arb_mode_t ARB_MODE     = ARB_FIXED,
  parameter int        STARVE_LIMIT = 8,
  parameter int        LOCK_MAX     = 16
) (
  input logic               clk,
  input logic               rst,
  mem_port_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;
  localparam int ID_W = $clog2(NUM_PORTS);
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  localparam int LC_W = $clog2(LOCK_MAX + 1);

  arb_state_t state, state_next;

  logic [ID_W-1:0]                 grant_id_q;
  logic                            grant_valid_q;
  logic [ID_W-1:0]                 last_grant;
  logic                            mem_ren_q, mem_wen_q;
  logic [ADDR_W-1:0]               mem_addr_q;
  logic [DATA_W-1:0]               mem_wdata_q;
  logic [BE_W-1:0]                 mem_byte_en_q;
  logic [NUM_PORTS-1:0][SC_W-1:0]  starve_cnt;
  logic                            lock_valid;
  logic [ID_W-1:0]                 lock_owner;
  logic [LC_W-1:0]                 lock_idle_cnt;

  logic [NUM_PORTS-1:0] req_any, candidates, starved;
  logic                 lock_active;
  logic [ID_W-1:0]      rr_start;
  logic                 rr_valid, low_valid, stv_valid, win_valid;
  logic [ID_W-1:0]      rr_idx, low_idx, stv_idx, win_idx;
  logic                 do_grant, complete;
  logic [NUM_PORTS-1:0] busy_vec;
  logic [DATA_W-1:0]    rdata_out;

  // Candidate set: a live lock restricts arbitration to its owner
  always_comb begin
    req_any     = bus.req_ren | bus.req_wen;
    lock_active = lock_valid && bus.req_lock[lock_owner];
    candidates  = req_any;
    if (lock_active) begin
      candidates             = '0;
      candidates[lock_owner] = req_any[lock_owner];
    end
    for (int i = 0; i < NUM_PORTS; i++) begin
      starved[i] = candidates[i] && (starve_cnt[i] == SC_W'(STARVE_LIMIT));
    end
    rr_start = (last_grant == ID_W'(NUM_PORTS - 1)) ? '0 : last_grant + 1'b1;
  end

  rr_priority_picker #(.N(NUM_PORTS), .IW(ID_W)) u_pick_rr (
    .req(candidates), .start(rr_start), .valid(rr_valid), .index(rr_idx)
  );

  rr_priority_picker #(.N(NUM_PORTS), .IW(ID_W)) u_pick_low (
    .req(candidates), .start('0), .valid(low_valid), .index(low_idx)
  );

  rr_priority_picker #(.N(NUM_PORTS), .IW(ID_W)) u_pick_starved (
    .req(starved), .start('0), .valid(stv_valid), .index(stv_idx)
  );

  // Winner: rotating pick in RR, otherwise promoted starvers before lowest index
  always_comb begin
    win_valid = low_valid;
    win_idx   = low_idx;
    if (ARB_MODE == ARB_RR) begin
      win_valid = rr_valid;
      win_idx   = rr_idx;
    end else if (stv_valid) begin
      win_valid = 1'b1;
      win_idx   = stv_idx;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state plus the completion-cycle handshake back to the requesters
  always_comb begin
    state_next = state;
    do_grant   = 1'b0;
    complete   = 1'b0;
    busy_vec   = '1;
    rdata_out  = '0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          do_grant   = 1'b1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (!bus.mem_busy) begin
          complete             = 1'b1;
          busy_vec[grant_id_q] = 1'b0;
          rdata_out            = bus.mem_rdata;
          state_next           = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winner's request into the downstream registers; drop it on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_byte_en_q <= '0;
      grant_valid_q <= 1'b0;
      grant_id_q    <= '0;
      last_grant    <= ID_W'(NUM_PORTS - 1);
    end else if (do_grant) begin
      mem_ren_q     <= bus.req_ren[win_idx] & ~bus.req_wen[win_idx];
      mem_wen_q     <= bus.req_wen[win_idx];
      mem_addr_q    <= bus.req_addr[win_idx];
      mem_wdata_q   <= bus.req_wdata[win_idx];
      mem_byte_en_q <= bus.req_byte_en[win_idx];
      grant_valid_q <= 1'b1;
      grant_id_q    <= win_idx;
      last_grant    <= win_idx;
    end else if (complete) begin
      mem_ren_q     <= 1'b0;
      mem_wen_q     <= 1'b0;
      grant_valid_q <= 1'b0;
    end
  end

  // Count lost arbitrations per requesting port so a waiter eventually gets promoted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (do_grant && (ARB_MODE == ARB_FIXED)) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (ID_W'(i) == win_idx) begin
          starve_cnt[i] <= '0;
        end else if (req_any[i] && (starve_cnt[i] < SC_W'(STARVE_LIMIT))) begin
          starve_cnt[i] <= starve_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lock ownership: taken on a locked completion, dropped when released or left idle too long
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_valid    <= 1'b0;
      lock_owner    <= '0;
      lock_idle_cnt <= '0;
    end else if (complete && bus.req_lock[grant_id_q]) begin
      lock_valid    <= 1'b1;
      lock_owner    <= grant_id_q;
      lock_idle_cnt <= '0;
    end else if ((state == IDLE) && lock_valid) begin
      if (!bus.req_lock[lock_owner]) begin
        lock_valid    <= 1'b0;
        lock_idle_cnt <= '0;
      end else if (req_any[lock_owner]) begin
        lock_idle_cnt <= '0;
      end else if (lock_idle_cnt == LC_W'(LOCK_MAX - 1)) begin
        lock_valid    <= 1'b0;
        lock_idle_cnt <= '0;
      end else begin
        lock_idle_cnt <= lock_idle_cnt + 1'b1;
      end
    end
  end

  assign bus.req_busy    = busy_vec;
  assign bus.req_rdata   = rdata_out;
  assign bus.mem_ren     = mem_ren_q;
  assign bus.mem_wen     = mem_wen_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_byte_en = mem_byte_en_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.grant_id    = grant_id_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: three instances cover fixed priority,
// round-robin and a short starvation limit.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  // Free-running clock, period 10
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) fix_bus ();
  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) rr_bus ();
  mem_port_arbiter_if #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32)) stv_bus ();

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FIXED),
                     .STARVE_LIMIT(8), .LOCK_MAX(16))
    dut_fix (.clk(clk), .rst(rst), .bus(fix_bus));

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_RR),
                     .STARVE_LIMIT(8), .LOCK_MAX(16))
    dut_rr (.clk(clk), .rst(rst), .bus(rr_bus));

  mem_port_arbiter #(.NUM_PORTS(3), .ADDR_W(32), .DATA_W(32), .ARB_MODE(ARB_FIXED),
                     .STARVE_LIMIT(2), .LOCK_MAX(16))
    dut_stv (.clk(clk), .rst(rst), .bus(stv_bus));

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    fix_bus.req_ren = '0; fix_bus.req_wen = '0; fix_bus.req_addr = '0;
    fix_bus.req_wdata = '0; fix_bus.req_byte_en = '0; fix_bus.req_lock = '0;
    fix_bus.mem_busy = 1'b1; fix_bus.mem_rdata = '0;
    rr_bus.req_ren = '0; rr_bus.req_wen = '0; rr_bus.req_addr = '0;
    rr_bus.req_wdata = '0; rr_bus.req_byte_en = '0; rr_bus.req_lock = '0;
    rr_bus.mem_busy = 1'b0; rr_bus.mem_rdata = '0;
    stv_bus.req_ren = '0; stv_bus.req_wen = '0; stv_bus.req_addr = '0;
    stv_bus.req_wdata = '0; stv_bus.req_byte_en = '0; stv_bus.req_lock = '0;
    stv_bus.mem_busy = 1'b0; stv_bus.mem_rdata = '0;
    rst = 1'b1;
    next_cycle();
    next_cycle();
    total++; if (fix_bus.req_busy !== 3'b111) begin bad++; $display("[TB] FAIL reset_busy_fix: got %b expected 111", fix_bus.req_busy); end
    total++; if (fix_bus.mem_ren !== 1'b0 || fix_bus.mem_wen !== 1'b0) begin bad++; $display("[TB] FAIL reset_mem_rw_fix: got ren=%b wen=%b expected 0 0", fix_bus.mem_ren, fix_bus.mem_wen); end
    total++; if (fix_bus.grant_valid !== 1'b0 || fix_bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL reset_grant_fix: got gv=%b id=%0d expected 0 0", fix_bus.grant_valid, fix_bus.grant_id); end
    total++; if (fix_bus.mem_addr !== 32'h0 || fix_bus.mem_wdata !== 32'h0 || fix_bus.mem_byte_en !== 4'h0) begin bad++; $display("[TB] FAIL reset_fields_fix: got %h %h %h expected zeros", fix_bus.mem_addr, fix_bus.mem_wdata, fix_bus.mem_byte_en); end
    total++; if (rr_bus.req_busy !== 3'b111 || rr_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rr: got busy=%b gv=%b expected 111 0", rr_bus.req_busy, rr_bus.grant_valid); end
    total++; if (stv_bus.req_busy !== 3'b111 || stv_bus.mem_ren !== 1'b0) begin bad++; $display("[TB] FAIL reset_stv: got busy=%b ren=%b expected 111 0", stv_bus.req_busy, stv_bus.mem_ren); end
    rst = 1'b0;
    next_cycle();
    total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL idle_after_reset: got gv=%b expected 0", fix_bus.grant_valid); end
  endtask

  task automatic test_fixed_priority;
    next_cycle();
    fix_bus.req_addr[0] = 32'h0000_1000;
    fix_bus.req_addr[2] = 32'h0000_2000;
    fix_bus.req_ren[0]  = 1'b1;
    fix_bus.req_ren[2]  = 1'b1;
    fix_bus.mem_busy    = 1'b1;
    fix_bus.mem_rdata   = 32'h1234_5678;
    #1;
    total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL fix_c0_gv: got %b expected 0", fix_bus.grant_valid); end
    next_cycle(); #1;
    total++; if (fix_bus.mem_ren !== 1'b1 || fix_bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL fix_c1_grant: got ren=%b id=%0d expected 1 0", fix_bus.mem_ren, fix_bus.grant_id); end
    total++; if (fix_bus.mem_addr !== 32'h0000_1000 || fix_bus.req_busy !== 3'b111) begin bad++; $display("[TB] FAIL fix_c1_fields: got addr=%h busy=%b expected 00001000 111", fix_bus.mem_addr, fix_bus.req_busy); end
    next_cycle(); #1;
    total++; if (fix_bus.mem_ren !== 1'b1 || fix_bus.req_busy !== 3'b111) begin bad++; $display("[TB] FAIL fix_c2_hold: got ren=%b busy=%b expected 1 111", fix_bus.mem_ren, fix_bus.req_busy); end
    next_cycle();
    fix_bus.mem_busy = 1'b0;
    #1;
    total++; if (fix_bus.mem_ren !== 1'b1 || fix_bus.req_busy !== 3'b110) begin bad++; $display("[TB] FAIL fix_c3_done: got ren=%b busy=%b expected 1 110", fix_bus.mem_ren, fix_bus.req_busy); end
    total++; if (fix_bus.req_rdata !== 32'h1234_5678) begin bad++; $display("[TB] FAIL fix_c3_rdata: got %h expected 12345678", fix_bus.req_rdata); end
    next_cycle();
    fix_bus.req_ren[0] = 1'b0;
    fix_bus.mem_busy   = 1'b1;
    #1;
    total++; if (fix_bus.grant_valid !== 1'b0 || fix_bus.mem_ren !== 1'b0) begin bad++; $display("[TB] FAIL fix_c4_bubble: got gv=%b ren=%b expected 0 0", fix_bus.grant_valid, fix_bus.mem_ren); end
    next_cycle();
    fix_bus.mem_busy = 1'b0;
    #1;
    total++; if (fix_bus.grant_id !== 2'd2 || fix_bus.mem_ren !== 1'b1 || fix_bus.mem_addr !== 32'h0000_2000) begin bad++; $display("[TB] FAIL fix_c5_port2: got id=%0d ren=%b addr=%h expected 2 1 00002000", fix_bus.grant_id, fix_bus.mem_ren, fix_bus.mem_addr); end
    total++; if (fix_bus.req_busy !== 3'b011) begin bad++; $display("[TB] FAIL fix_c5_busy: got %b expected 011", fix_bus.req_busy); end
    next_cycle();
    fix_bus.req_ren[2] = 1'b0;
    #1;
    total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL fix_c6_idle: got %b expected 0", fix_bus.grant_valid); end
  endtask

  task automatic test_write_priority;
    next_cycle();
    fix_bus.req_ren[2]     = 1'b1;
    fix_bus.req_wen[2]     = 1'b1;
    fix_bus.req_addr[2]    = 32'h8000_0010;
    fix_bus.req_wdata[2]   = 32'hDEAD_BEEF;
    fix_bus.req_byte_en[2] = 4'b1010;
    fix_bus.mem_busy       = 1'b0;
    #1;
    next_cycle(); #1;
    total++; if (fix_bus.mem_wen !== 1'b1 || fix_bus.mem_ren !== 1'b0) begin bad++; $display("[TB] FAIL wr_dir: got wen=%b ren=%b expected 1 0", fix_bus.mem_wen, fix_bus.mem_ren); end
    total++; if (fix_bus.mem_addr !== 32'h8000_0010 || fix_bus.mem_wdata !== 32'hDEAD_BEEF || fix_bus.mem_byte_en !== 4'b1010) begin bad++; $display("[TB] FAIL wr_fields: got %h %h %b expected 80000010 deadbeef 1010", fix_bus.mem_addr, fix_bus.mem_wdata, fix_bus.mem_byte_en); end
    total++; if (fix_bus.grant_id !== 2'd2 || fix_bus.req_busy !== 3'b011) begin bad++; $display("[TB] FAIL wr_grant: got id=%0d busy=%b expected 2 011", fix_bus.grant_id, fix_bus.req_busy); end
    next_cycle();
    fix_bus.req_ren[2] = 1'b0;
    fix_bus.req_wen[2] = 1'b0;
    #1;
    total++; if (fix_bus.mem_wen !== 1'b0 || fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL wr_release: got wen=%b gv=%b expected 0 0", fix_bus.mem_wen, fix_bus.grant_valid); end
  endtask

  task automatic test_lock;
    next_cycle();
    fix_bus.req_addr[1] = 32'h0000_3000;
    fix_bus.req_ren[1]  = 1'b1;
    fix_bus.req_lock[1] = 1'b1;
    fix_bus.mem_busy    = 1'b0;
    #1;
    next_cycle();
    fix_bus.req_addr[0] = 32'h0000_1000;
    fix_bus.req_ren[0]  = 1'b1;
    #1;
    total++; if (fix_bus.grant_id !== 2'd1 || fix_bus.req_busy !== 3'b101) begin bad++; $display("[TB] FAIL lock_first: got id=%0d busy=%b expected 1 101", fix_bus.grant_id, fix_bus.req_busy); end
    next_cycle(); #1;
    total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL lock_bubble: got %b expected 0", fix_bus.grant_valid); end
    next_cycle(); #1;
    total++; if (fix_bus.grant_valid !== 1'b1 || fix_bus.grant_id !== 2'd1) begin bad++; $display("[TB] FAIL lock_regrant: got gv=%b id=%0d expected 1 1", fix_bus.grant_valid, fix_bus.grant_id); end
    next_cycle();
    fix_bus.req_ren[1] = 1'b0;
    #1;
    for (int c = 4; c <= 20; c++) begin
      if (c > 4) begin
        next_cycle(); #1;
      end
      total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL lock_hold_c%0d: got gv=%b id=%0d expected gv 0", c, fix_bus.grant_valid, fix_bus.grant_id); end
    end
    next_cycle(); #1;
    total++; if (fix_bus.grant_valid !== 1'b1 || fix_bus.grant_id !== 2'd0) begin bad++; $display("[TB] FAIL lock_timeout_grant: got gv=%b id=%0d expected 1 0", fix_bus.grant_valid, fix_bus.grant_id); end
    total++; if (fix_bus.req_busy !== 3'b110) begin bad++; $display("[TB] FAIL lock_timeout_busy: got %b expected 110", fix_bus.req_busy); end
    next_cycle();
    fix_bus.req_ren[0]  = 1'b0;
    fix_bus.req_lock[1] = 1'b0;
    #1;
    total++; if (fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL lock_end_idle: got %b expected 0", fix_bus.grant_valid); end
  endtask

  task automatic test_starvation;
    logic [1:0] exp_id [3];
    exp_id[0] = 2'd0; exp_id[1] = 2'd0; exp_id[2] = 2'd1;
    next_cycle();
    stv_bus.req_ren[0] = 1'b1;
    stv_bus.req_ren[1] = 1'b1;
    stv_bus.mem_busy   = 1'b0;
    #1;
    for (int c = 1; c <= 5; c++) begin
      next_cycle(); #1;
      if (c % 2 == 1) begin
        total++; if (stv_bus.grant_valid !== 1'b1 || stv_bus.grant_id !== exp_id[c/2]) begin bad++; $display("[TB] FAIL starve_c%0d: got gv=%b id=%0d expected 1 %0d", c, stv_bus.grant_valid, stv_bus.grant_id, exp_id[c/2]); end
      end else begin
        total++; if (stv_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL starve_gap_c%0d: got %b expected 0", c, stv_bus.grant_valid); end
      end
    end
    total++; if (stv_bus.req_busy !== 3'b101) begin bad++; $display("[TB] FAIL starve_busy: got %b expected 101", stv_bus.req_busy); end
    next_cycle();
    stv_bus.req_ren = '0;
    #1;
    total++; if (stv_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL starve_end: got %b expected 0", stv_bus.grant_valid); end
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_id [4];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2; exp_id[3] = 2'd0;
    next_cycle();
    rr_bus.req_ren  = 3'b111;
    rr_bus.mem_busy = 1'b0;
    #1;
    for (int c = 1; c <= 7; c++) begin
      next_cycle(); #1;
      if (c % 2 == 1) begin
        total++; if (rr_bus.grant_valid !== 1'b1 || rr_bus.grant_id !== exp_id[c/2]) begin bad++; $display("[TB] FAIL rr_c%0d: got gv=%b id=%0d expected 1 %0d", c, rr_bus.grant_valid, rr_bus.grant_id, exp_id[c/2]); end
      end else begin
        total++; if (rr_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_gap_c%0d: got %b expected 0", c, rr_bus.grant_valid); end
      end
    end
    next_cycle();
    rr_bus.req_ren = '0;
    #1;
    total++; if (rr_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rr_end: got %b expected 0", rr_bus.grant_valid); end
  endtask

  task automatic test_reset_mid_access;
    next_cycle();
    fix_bus.req_addr[1] = 32'h0000_4000;
    fix_bus.req_ren[1]  = 1'b1;
    fix_bus.mem_busy    = 1'b1;
    #1;
    next_cycle(); #1;
    total++; if (fix_bus.mem_ren !== 1'b1 || fix_bus.grant_id !== 2'd1) begin bad++; $display("[TB] FAIL rst_pre: got ren=%b id=%0d expected 1 1", fix_bus.mem_ren, fix_bus.grant_id); end
    next_cycle();
    rst = 1'b1;
    fix_bus.req_ren[0] = 1'b1;
    #1;
    total++; if (fix_bus.mem_ren !== 1'b0 || fix_bus.grant_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async: got ren=%b gv=%b expected 0 0", fix_bus.mem_ren, fix_bus.grant_valid); end
    total++; if (fix_bus.req_busy !== 3'b111 || fix_bus.grant_id !== 2'd0 || fix_bus.mem_addr !== 32'h0) begin bad++; $display("[TB] FAIL rst_values: got busy=%b id=%0d addr=%h expected 111 0 0", fix_bus.req_busy, fix_bus.grant_id, fix_bus.mem_addr); end
    next_cycle();
    rst = 1'b0;
    #1;
    next_cycle(); #1;
    total++; if (fix_bus.grant_valid !== 1'b1 || fix_bus.grant_id !== 2'd0 || fix_bus.mem_ren !== 1'b1) begin bad++; $display("[TB] FAIL rst_port0_first: got gv=%b id=%0d ren=%b expected 1 0 1", fix_bus.grant_valid, fix_bus.grant_id, fix_bus.mem_ren); end
    fix_bus.req_ren  = '0;
    fix_bus.mem_busy = 1'b0;
  endtask

  // Run every scenario in order, then report
  initial begin
    $display("[TB] starting mem_port_arbiter bench");
    test_reset();
    test_fixed_priority();
    test_write_priority();
    test_lock();
    test_starvation();
    test_round_robin();
    test_reset_mid_access();
    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
